// File: rtl/touch_pkg.sv
// Shared types and constants for the touchscreen packet receiver.
// Holds receiver/parser state encodings and the record layout.
package touch_pkg;

  localparam int SYNC_BIT = 7;
  localparam int PKT_LEN  = 5;
  localparam int COORD_W  = 12;
  localparam int PST_W    = $clog2(PKT_LEN);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [PST_W-1:0] {
    P_WAIT_SYNC,
    P_GOT0,
    P_GOT1,
    P_GOT2,
    P_GOT3
  } pkt_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               pen;
  } touch_rec_t;

  function automatic logic [COORD_W-1:0] coord(
    input logic [6:0] lo,
    input logic [4:0] hi
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with 2-flop input synchronizer.
// Strobe and frame error are decoded on the stop-bit sample cycle.
module uart_rx_byte
  import touch_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_strobe,
  output logic       o_ferr
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CNT_W   = $clog2(BIT_CYC + 1);

  logic [1:0]       r_sync;
  logic             r_prev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;

  logic w_rxd;
  logic w_half;
  logic w_full;
  logic w_stop;

  assign w_rxd  = r_sync[1];
  assign w_half = (r_cnt == CNT_W'(HALF - 1));
  assign w_full = (r_cnt == CNT_W'(BIT_CYC - 1));
  assign w_stop = (r_state == RX_STOP) && w_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync <= {r_sync[0], i_rxd};
      r_prev <= w_rxd;
      unique case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_prev && !w_rxd)
            r_state <= RX_START;
        end
        RX_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rxd ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7)
              r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_data   = r_shift;
  assign o_strobe = w_stop && w_rxd;
  assign o_ferr   = w_stop && !w_rxd;

endmodule

// File: rtl/touch_packet_rx.sv
// Touch controller packet parser with a valid/ready output register.
// Overwrites an unconsumed record and flags it as a sticky overrun.
module touch_packet_rx
  import touch_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               touchscreen_rxd,
  output logic               touch_valid,
  input  logic               touch_ready,
  output logic [COORD_W-1:0] touch_x,
  output logic [COORD_W-1:0] touch_y,
  output logic               touch_pen,
  output logic               err_overrun,
  output logic               err_frame,
  input  logic               err_clear
);

  logic [7:0] w_byte;
  logic       w_byte_stb;
  logic       w_ferr;
  logic       w_sync;
  logic       w_done;
  logic       w_xfer;
  touch_rec_t w_rec;

  pkt_state_t r_pstate;
  logic       r_pen;
  logic [6:0] r_x_lo;
  logic [4:0] r_x_hi;
  logic [6:0] r_y_lo;
  touch_rec_t r_rec;
  logic       r_valid;
  logic       r_ovr;
  logic       r_err_frame;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .i_clk    (clk_clk),
    .i_rst_n  (reset_reset_n),
    .i_rxd    (touchscreen_rxd),
    .o_data   (w_byte),
    .o_strobe (w_byte_stb),
    .o_ferr   (w_ferr)
  );

  assign w_sync = w_byte[SYNC_BIT];
  assign w_done = w_byte_stb && !w_sync && (r_pstate == P_GOT3);
  assign w_xfer = r_valid && touch_ready;

  assign w_rec.x   = coord(r_x_lo, r_x_hi);
  assign w_rec.y   = coord(r_y_lo, w_byte[4:0]);
  assign w_rec.pen = r_pen;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_pstate <= P_WAIT_SYNC;
      r_pen    <= 1'b0;
      r_x_lo   <= '0;
      r_x_hi   <= '0;
      r_y_lo   <= '0;
    end else if (w_ferr) begin
      r_pstate <= P_WAIT_SYNC;
    end else if (w_byte_stb) begin
      if (w_sync) begin
        r_pen    <= w_byte[0];
        r_pstate <= P_GOT0;
      end else begin
        unique case (r_pstate)
          P_WAIT_SYNC: ;
          P_GOT0: begin
            r_x_lo   <= w_byte[6:0];
            r_pstate <= P_GOT1;
          end
          P_GOT1: begin
            r_x_hi   <= w_byte[4:0];
            r_pstate <= P_GOT2;
          end
          P_GOT2: begin
            r_y_lo   <= w_byte[6:0];
            r_pstate <= P_GOT3;
          end
          P_GOT3:  r_pstate <= P_WAIT_SYNC;
          default: r_pstate <= P_WAIT_SYNC;
        endcase
      end
    end
  end

  // a completion during a transfer reloads without counting as overrun
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rec       <= '0;
      r_valid     <= 1'b0;
      r_ovr       <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_err_frame <= w_ferr;
      if (w_done) begin
        r_rec   <= w_rec;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_done && r_valid && !touch_ready)
        r_ovr <= 1'b1;
      else if (err_clear)
        r_ovr <= 1'b0;
    end
  end

  assign touch_valid = r_valid;
  assign touch_x     = r_rec.x;
  assign touch_y     = r_rec.y;
  assign touch_pen   = r_rec.pen;
  assign err_overrun = r_ovr;
  assign err_frame   = r_err_frame;

endmodule

// File: tb/tb_touch_packet_rx.sv
// Scoreboard bench for touch_packet_rx at 9600 baud.
// Clock is 960 kHz so one bit spans 100 cycles.
`timescale 1ns/1ps
module tb_touch_packet_rx;
  import touch_pkg::*;

  localparam int  CLK_HZ  = 960_000;
  localparam int  BAUD    = 9600;
  localparam int  BIT_CYC = CLK_HZ / BAUD;
  localparam real TCLK    = 1.0e9 / CLK_HZ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        ready = 1'b0;
  logic        clr = 1'b0;
  logic        valid;
  logic [11:0] tx;
  logic [11:0] ty;
  logic        pen;
  logic        ovr;
  logic        ferr;

  touch_packet_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .touchscreen_rxd (rxd),
    .touch_valid     (valid),
    .touch_ready     (ready),
    .touch_x         (tx),
    .touch_y         (ty),
    .touch_pen       (pen),
    .err_overrun     (ovr),
    .err_frame       (ferr),
    .err_clear       (clr)
  );

  always #(TCLK / 2.0) clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         n_frame = 0;
  int         n_stb = 0;
  touch_rec_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic touch_rec_t mk(input logic [11:0] x,
                                    input logic [11:0] y,
                                    input logic p);
    touch_rec_t r;
    r.x = x;
    r.y = y;
    r.pen = p;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      touch_rec_t e;
      if (ferr) n_frame++;
      if (dut.w_byte_stb) n_stb++;
      if (valid && ready) begin
        check("rec_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rec", 32'({tx, ty, pen}), 32'(e));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT_CYC) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3,
                          input logic [7:0] b4);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 * BIT_CYC && exp_q.size() != 0; i++)
      @(negedge clk);
    repeat (5) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_xyp"}, {tx, ty, pen}, 0);
    check({tag, "_ovr"}, ovr, 0);
    check({tag, "_ferr"}, ferr, 0);
  endtask

  initial begin
    #(TCLK * 90000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int s0;
    repeat (5) @(negedge clk);
    check_reset_outs("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outs("post_rst");

    // basic packet, consumer always ready
    ready = 1'b1;
    exp_q.push_back(mk(12'h62A, 12'h195, 1'b1));
    send_pkt(8'h81, 8'h2A, 8'h0C, 8'h15, 8'h03);
    wait_drain("s1_drain");
    check("s1_ovr", ovr, 0);
    check("s1_frame", n_frame, 0);

    // overrun while stalled
    ready = 1'b0;
    send_pkt(8'h81, 8'h2A, 8'h0C, 8'h15, 8'h03);
    check("s2_valid", valid, 1);
    check("s2_hold", {tx, ty, pen}, {12'h62A, 12'h195, 1'b1});
    check("s2_ovr0", ovr, 0);
    exp_q.push_back(mk(12'h001, 12'h002, 1'b0));
    send_pkt(8'h80, 8'h01, 8'h00, 8'h02, 8'h00);
    check("s2_new", {tx, ty, pen}, {12'h001, 12'h002, 1'b0});
    check("s2_ovr1", ovr, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("s2_clr", ovr, 0);
    ready = 1'b1;
    wait_drain("s2_drain");

    // truncated packet superseded by a new sync
    exp_q.push_back(mk(12'd5, 12'd6, 1'b0));
    send_byte(8'h81);
    send_byte(8'h2A);
    send_pkt(8'h80, 8'h05, 8'h00, 8'h06, 8'h00);
    wait_drain("s3_drain");

    // framing error on B2
    f0 = n_frame;
    send_byte(8'h81);
    send_byte(8'h2A);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h15);
    send_byte(8'h03);
    check("s4_frame", n_frame - f0, 1);
    check("s4_norec", valid, 0);
    exp_q.push_back(mk(12'h62A, 12'h195, 1'b1));
    send_pkt(8'h81, 8'h2A, 8'h0C, 8'h15, 8'h03);
    wait_drain("s4_drain");

    // 200 ns glitch straddling a rising edge
    f0 = n_frame;
    s0 = n_stb;
    @(negedge clk);
    #(TCLK / 2.0 - 100.0);
    rxd = 1'b0;
    #200.0;
    rxd = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    check("s5_stb", n_stb - s0, 0);
    check("s5_frame", n_frame - f0, 0);
    check("s5_valid", valid, 0);

    // reset mid-packet
    send_byte(8'h81);
    send_byte(8'h2A);
    send_byte(8'h0C);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("s6_rst");
    rst_n = 1'b1;
    send_byte(8'h15);
    send_byte(8'h03);
    check("s6_norec", valid, 0);
    exp_q.push_back(mk(12'h087, 12'h108, 1'b0));
    send_pkt(8'h80, 8'h07, 8'h01, 8'h08, 8'h02);
    wait_drain("s6_drain");
    check("end_ovr", ovr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/touch_packet_rx.md
TOUCH_PACKET_RX -- requirements
Module: touch_packet_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, touchscreen UART bit rate; BIT_CYC = CLK_HZ/BAUD, integer division.
REQ-003 SHALL have port clk_clk  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port reset_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port touchscreen_rxd  input  1  asynchronous serial line from the touch controller, idle high, 8N1, LSB first.
REQ-006 SHALL have port touch_valid  output  1  coordinate record available.
REQ-007 SHALL have port touch_ready  input  1  consumer accepts the record this cycle.
REQ-008 SHALL have port touch_x  output  12  X coordinate.
REQ-009 SHALL have port touch_y  output  12  Y coordinate.
REQ-010 SHALL have port touch_pen  output  1  1 = pen down, 0 = pen up.
REQ-011 SHALL have port err_overrun  output  1  sticky: an unconsumed record was overwritten.
REQ-012 SHALL have port err_frame  output  1  one-cycle pulse on a framing error (stop bit sampled 0).
REQ-013 SHALL have port err_clear  input  1  clears err_overrun.

Function
REQ-014 SHALL pass touchscreen_rxd through a 2-flop synchronizer reset to 1; all decoding uses the synchronized value.
REQ-015 Byte receiver SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START on synchronized falling edge.
- START: sample at BIT_CYC/2; low -> DATA, high -> IDLE (false start, no error).
- DATA: 8 samples BIT_CYC apart, LSB first.
- STOP: sample after BIT_CYC; 1 -> one-cycle byte strobe; 0 -> err_frame pulse, byte discarded.
- Always returns to IDLE.
REQ-016 Packet format SHALL be 5 bytes:
- B0 = 1xxxxxxP (bit7 = 1 sync, bit0 = pen).
- B1 = X[6:0], B2[4:0] = X[11:7], B3 = Y[6:0], B4[4:0] = Y[11:7].
- B1..B4 have bit7 = 0; B2/B4 bits 6:5 are ignored.
REQ-017 Packet parser SHALL have states WAIT_SYNC, GOT0..GOT3.
- Byte with bit7 = 1 in any state: latch pen, go to GOT0.
- Byte with bit7 = 0 in WAIT_SYNC: ignored.
- Byte with bit7 = 0 in GOTn: store, advance; the byte received in GOT3 completes the packet -> WAIT_SYNC.
REQ-018 A framing error SHALL force the parser to WAIT_SYNC.
REQ-019 On packet completion, the assembled x, y and pen SHALL be loaded into the output register and touch_valid SHALL be 1 on the cycle after the stop-bit sample of B4.
REQ-020 touch_x, touch_y and touch_pen SHALL be stable while touch_valid = 1 and touch_ready = 0, except on overwrite per REQ-022.
REQ-021 A transfer SHALL occur when touch_valid and touch_ready are both 1; touch_valid SHALL deassert the next cycle unless a new packet completes in the same cycle.
REQ-022 If a completion occurs while touch_valid = 1 and touch_ready = 0:
- The new record overwrites the register.
- err_overrun sets to 1 next cycle.
REQ-023 Completion coinciding with a transfer SHALL load the new record, keep touch_valid = 1, and SHALL NOT set err_overrun.
REQ-024 err_clear SHALL clear err_overrun next cycle; a simultaneous set wins over the clear.

Reset
REQ-025 While reset_reset_n = 0, all of the following SHALL hold:
- touch_valid, touch_x, touch_y, touch_pen, err_overrun and err_frame are 0.
- The receiver is in IDLE and the parser is in WAIT_SYNC.
- Synchronizer flops are 1 and counters are 0.
REQ-026 Reset asserted mid-byte or mid-packet SHALL discard the partial data; the first valid record after release requires a complete new B0..B4 sequence.

Structure
REQ-027 Shared package touch_pkg SHALL hold:
- Receiver and parser state enums.
- SYNC_BIT = 7, PKT_LEN = 5, COORD_W = 12.
REQ-028 The byte receiver SHALL be sub-module uart_rx_byte (ports: clock, reset, rxd, byte data, byte strobe, frame error); parser and output register live in touch_packet_rx.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Bytes 0x81,0x2A,0x0C,0x15,0x03 at 9600 baud, touch_ready = 1 -> one valid beat with x = 0x62A, y = 0x195, pen = 1, no errors.
- Same packet with touch_ready = 0, then a second packet 0x80,0x01,0x00,0x02,0x00 -> x = 0x001, y = 0x002, pen = 0, err_overrun = 1; err_clear -> err_overrun = 0.
- 0x81,0x2A, then 0x80,0x05,0x00,0x06,0x00 -> single record x = 5, y = 6, pen = 0; the truncated packet produces nothing.
- B2 sent with stop bit 0 -> err_frame pulses once, no record; next full packet decodes correctly.
- 200 ns low glitch on rxd -> no byte strobe, no error.
- Reset pulsed after B2 of a packet, then a full packet -> exactly one record, equal to the post-reset packet.
